// File: rtl/exec_controller.sv
// Run/step/halt execution controller for a single-cycle RISC-V datapath.
// Gates commits, handles breakpoints, HALT encodings and step counting.
module exec_controller #(
  parameter int unsigned STEP_W    = 16,
  parameter logic [31:0] HALT_WORD = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run_req,
  input  logic              step_req,
  input  logic              halt_req,
  input  logic [STEP_W-1:0] step_count,
  input  logic              bp_en,
  input  logic [31:0]       bp_addr,
  input  logic [31:0]       pc,
  input  logic [31:0]       instr,
  output logic              cpu_en,
  output logic [1:0]        state,
  output logic              halted,
  output logic              bp_hit,
  output logic [31:0]       retired
);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_STEP = 2'b10,
    S_HALT = 2'b11
  } state_e;

  state_e            state_q, state_d;
  logic [STEP_W-1:0] rem_q, rem_d;
  logic              skip_q, skip_d;
  logic              bp_hit_q, bp_hit_d;
  logic [31:0]       retired_q, retired_d;

  logic active;
  logic stop_halt;
  logic stop_bp;
  logic stop_hw;
  logic stop;
  logic start_ok;

  assign active    = (state_q == S_RUN) || (state_q == S_STEP);
  assign stop_halt = halt_req;
  assign stop_bp   = bp_en && (pc == bp_addr) && !skip_q;
  assign stop_hw   = (instr == HALT_WORD);
  assign stop      = stop_halt || stop_bp || stop_hw;
  // rst gating keeps cpu_en low the instant reset is asserted
  assign cpu_en    = rst && active && !stop;
  assign start_ok  = !halt_req;

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    skip_d    = skip_q;
    bp_hit_d  = bp_hit_q;
    retired_d = retired_q;
    if (cpu_en) begin
      retired_d = retired_q + 32'd1;
    end
    unique case (state_q)
      S_IDLE, S_HALT: begin
        if (start_ok && step_req) begin
          state_d  = S_STEP;
          rem_d    = (step_count == '0) ? {{(STEP_W-1){1'b0}}, 1'b1}
                                        : step_count;
          bp_hit_d = 1'b0;
          skip_d   = 1'b1;
        end else if (start_ok && run_req) begin
          state_d  = S_RUN;
          bp_hit_d = 1'b0;
          skip_d   = 1'b1;
        end
      end
      S_RUN, S_STEP: begin
        skip_d = 1'b0;
        if (stop) begin
          state_d = S_HALT;
          // halt_req outranks a coincident breakpoint as the stop cause
          if (stop_bp && !stop_halt) begin
            bp_hit_d = 1'b1;
          end
        end else if (state_q == S_STEP) begin
          rem_d = rem_q - {{(STEP_W-1){1'b0}}, 1'b1};
          if (rem_q == {{(STEP_W-1){1'b0}}, 1'b1}) begin
            state_d = S_HALT;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      rem_q     <= '0;
      skip_q    <= 1'b0;
      bp_hit_q  <= 1'b0;
      retired_q <= '0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      skip_q    <= skip_d;
      bp_hit_q  <= bp_hit_d;
      retired_q <= retired_d;
    end
  end

  assign state   = state_q;
  assign halted  = (state_q == S_HALT);
  assign bp_hit  = bp_hit_q;
  assign retired = retired_q;

endmodule

// File: tb/tb_exec_controller.sv
// Directed bench for exec_controller with a tiny PC/instruction model.
// The model advances pc by 4 on every sampled commit.
module tb_exec_controller;

  localparam logic [31:0] HW  = 32'hFFFF_FFFF;
  localparam logic [31:0] NOP = 32'h0000_0013;

  logic        clk;
  logic        rst;
  logic        run_req;
  logic        step_req;
  logic        halt_req;
  logic [15:0] step_count;
  logic        bp_en;
  logic [31:0] bp_addr;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        cpu_en;
  logic [1:0]  state;
  logic        halted;
  logic        bp_hit;
  logic [31:0] retired;

  logic [31:0] halt_pc;
  int          checks;
  int          failures;
  int          ncommit;
  int          base;

  assign instr = (pc == halt_pc) ? HW : NOP;

  exec_controller #(.STEP_W(16), .HALT_WORD(HW)) dut (
    .clk(clk),
    .rst(rst),
    .run_req(run_req),
    .step_req(step_req),
    .halt_req(halt_req),
    .step_count(step_count),
    .bp_en(bp_en),
    .bp_addr(bp_addr),
    .pc(pc),
    .instr(instr),
    .cpu_en(cpu_en),
    .state(state),
    .halted(halted),
    .bp_hit(bp_hit),
    .retired(retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    logic en;
    @(negedge clk);
    en = cpu_en;
    @(posedge clk);
    #1;
    if (en) begin
      pc = pc + 32'd4;
      ncommit++;
    end
  endtask

  task automatic run_to_halt(input int maxc);
    for (int i = 0; i < maxc; i++) begin
      if (state == 2'b11) break;
      cycle();
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    pc = 32'h0;
    ncommit = 0;
    #2;
    rst = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0;
    failures = 0;
    ncommit = 0;
    rst = 1'b0;
    run_req = 1'b0;
    step_req = 1'b0;
    halt_req = 1'b0;
    step_count = 16'd0;
    bp_en = 1'b0;
    bp_addr = 32'h0;
    pc = 32'h0;
    halt_pc = 32'hFFFF_FF00;
    #12;
    chk("rst_state", {30'd0, state}, 32'd0);
    chk("rst_cpu_en", {31'd0, cpu_en}, 32'd0);
    chk("rst_halted", {31'd0, halted}, 32'd0);
    chk("rst_bp_hit", {31'd0, bp_hit}, 32'd0);
    chk("rst_retired", retired, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;

    // free run until HALT word at the 5th fetch
    halt_pc = 32'h10;
    run_req = 1'b1;
    cycle();
    run_req = 1'b0;
    chk("run_state", {30'd0, state}, 32'd1);
    run_to_halt(20);
    chk("hw_state", {30'd0, state}, 32'd3);
    chk("hw_halted", {31'd0, halted}, 32'd1);
    chk("hw_retired", retired, 32'd4);
    chk("hw_commits", ncommit, 32'd4);
    chk("hw_cpu_en", {31'd0, cpu_en}, 32'd0);
    chk("hw_bp_hit", {31'd0, bp_hit}, 32'd0);

    // step 3, then step 0 (treated as 1)
    halt_pc = 32'hFFFF_FF00;
    do_reset();
    step_count = 16'd3;
    step_req = 1'b1;
    cycle();
    step_req = 1'b0;
    chk("step_state", {30'd0, state}, 32'd2);
    run_to_halt(20);
    chk("step3_halted", {31'd0, halted}, 32'd1);
    chk("step3_retired", retired, 32'd3);
    chk("step3_commits", ncommit, 32'd3);
    step_count = 16'd0;
    step_req = 1'b1;
    cycle();
    step_req = 1'b0;
    run_to_halt(20);
    chk("step0_retired", retired, 32'd4);
    chk("step0_commits", ncommit, 32'd4);
    chk("step0_state", {30'd0, state}, 32'd3);

    // breakpoint at 0x10 and resume past it
    do_reset();
    bp_en = 1'b1;
    bp_addr = 32'h10;
    run_req = 1'b1;
    cycle();
    run_req = 1'b0;
    run_to_halt(20);
    chk("bp_pc", pc, 32'h10);
    chk("bp_retired", retired, 32'd4);
    chk("bp_hit_set", {31'd0, bp_hit}, 32'd1);
    chk("bp_state", {30'd0, state}, 32'd3);
    run_req = 1'b1;
    cycle();
    run_req = 1'b0;
    chk("bp_resume_clr", {31'd0, bp_hit}, 32'd0);
    chk("bp_resume_en", {31'd0, cpu_en}, 32'd1);
    cycle();
    chk("bp_resume_ret", retired, 32'd5);
    chk("bp_resume_pc", pc, 32'h14);

    // halt_req in a RUN cycle
    halt_req = 1'b1;
    #1;
    chk("halt_cpu_en", {31'd0, cpu_en}, 32'd0);
    cycle();
    halt_req = 1'b0;
    chk("halt_state", {30'd0, state}, 32'd3);
    chk("halt_bp_hit", {31'd0, bp_hit}, 32'd0);
    chk("halt_retired", retired, 32'd5);

    // run+step together: step wins
    step_count = 16'd2;
    run_req = 1'b1;
    step_req = 1'b1;
    cycle();
    run_req = 1'b0;
    step_req = 1'b0;
    chk("both_state", {30'd0, state}, 32'd2);
    base = ncommit;
    run_to_halt(20);
    chk("both_commits", ncommit - base, 32'd2);
    chk("both_retired", retired, 32'd7);
    halt_req = 1'b1;
    run_req = 1'b1;
    cycle();
    halt_req = 1'b0;
    run_req = 1'b0;
    chk("blk_state", {30'd0, state}, 32'd3);
    cycle();
    chk("blk_retired", retired, 32'd7);

    // async reset mid-STEP
    step_count = 16'd100;
    step_req = 1'b1;
    cycle();
    step_req = 1'b0;
    cycle();
    cycle();
    chk("pre_rst_ret", retired, 32'd9);
    chk("pre_rst_en", {31'd0, cpu_en}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    chk("arst_cpu_en", {31'd0, cpu_en}, 32'd0);
    chk("arst_state", {30'd0, state}, 32'd0);
    chk("arst_retired", retired, 32'd0);
    chk("arst_halted", {31'd0, halted}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    cycle();
    chk("post_rst_state", {30'd0, state}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/exec_controller.md
EXEC_CONTROLLER -- requirements
Module: exec_controller

Interface
REQ-001 SHALL provide parameter STEP_W, default 16, width of step count and remaining-step counter.
REQ-002 SHALL provide parameter HALT_WORD, default 32'hFFFF_FFFF, instruction encoding treated as HALT.
REQ-003 SHALL provide port clk  input  1  single system clock; all state updates on rising edge.
REQ-004 SHALL provide port rst  input  1  reset, asynchronous, active-low (0 = reset).
REQ-005 SHALL provide port run_req  input  1  one-cycle request: free-run the processor.
REQ-006 SHALL provide port step_req  input  1  one-cycle request: execute step_count instructions.
REQ-007 SHALL provide port halt_req  input  1  request: stop before next instruction.
REQ-008 SHALL provide port step_count  input  STEP_W  instructions per step command; 0 treated as 1.
REQ-009 SHALL provide port bp_en  input  1  breakpoint enable.
REQ-010 SHALL provide port bp_addr  input  32  breakpoint PC value.
REQ-011 SHALL provide port pc  input  32  current PC of datapath.
REQ-012 SHALL provide port instr  input  32  instruction currently fetched at pc.
REQ-013 SHALL provide port cpu_en  output  1  commit enable: gates PC update, RegWrite, MemWrite this cycle.
REQ-014 SHALL provide port state  output  2  FSM state: 00 IDLE, 01 RUN, 10 STEP, 11 HALTED.
REQ-015 SHALL provide port halted  output  1  high when state is HALTED.
REQ-016 SHALL provide port bp_hit  output  1  sticky: last stop caused by breakpoint.
REQ-017 SHALL provide port retired  output  32  count of committed instructions.

Function
REQ-018 SHALL compute cpu_en combinationally: 1 only in RUN or STEP with no stop condition in the same cycle.
REQ-019 SHALL define stop conditions, priority high to low: halt_req; breakpoint (bp_en, pc==bp_addr, skip_bp clear); instr==HALT_WORD.
REQ-020 SHALL, on any stop condition in RUN/STEP, hold cpu_en=0 that cycle and enter HALTED next edge; the stopping instruction is not committed.
REQ-021 SHALL set bp_hit at the edge where a breakpoint stop is taken; halt_req or HALT_WORD stops leave bp_hit unchanged.
REQ-022 SHALL in IDLE/HALTED, on step_req, enter STEP, load remaining=max(step_count,1), clear bp_hit, set skip_bp.
REQ-023 SHALL in IDLE/HALTED, on run_req without step_req, enter RUN, clear bp_hit, set skip_bp; step_req wins when both asserted.
REQ-024 SHALL ignore halt_req in IDLE/HALTED, except that halt_req concurrent with run_req/step_req blocks the start (state unchanged).
REQ-025 SHALL clear skip_bp after the first cycle in RUN/STEP, so resuming at bp_addr commits that instruction once.
REQ-026 SHALL in STEP decrement remaining on each cpu_en=1 cycle; when remaining==1 and cpu_en=1, enter HALTED next edge.
REQ-027 SHALL ignore run_req/step_req while in RUN or STEP.
REQ-028 SHALL increment retired by 1 on every edge where cpu_en=1, wrapping 32'hFFFF_FFFF -> 0.
REQ-029 SHALL never leave HALTED or IDLE without run_req/step_req; HALTED is not returned to IDLE except by reset.

Reset
REQ-030 SHALL, while rst=0, asynchronously force state=IDLE, cpu_en=0, halted=0, bp_hit=0, retired=0, remaining=0, skip_bp=0.
REQ-031 SHALL, on reset asserted mid-RUN/STEP, drop cpu_en in the same cycle without waiting for a clock edge.
REQ-032 SHALL resume evaluation on the first rising clk after rst returns to 1.

Verification
REQ-033 SHALL verify: reset release, run_req pulse, bp_en=0, HALT_WORD at 5th fetch -> cpu_en high 4 cycles, state=11, retired=4.
REQ-034 SHALL verify: step_req with step_count=3 from IDLE -> exactly 3 cpu_en cycles, then halted=1, retired=3; step_count=0 -> exactly 1.
REQ-035 SHALL verify: bp_en=1, bp_addr=0x10, run from PC 0 (+4 per commit) -> stop with pc=0x10, retired=4, bp_hit=1; run_req again -> instruction at 0x10 commits, bp_hit=0.
REQ-036 SHALL verify: halt_req asserted in RUN cycle N -> cpu_en=0 in cycle N, state=11 after edge, bp_hit=0.
REQ-037 SHALL verify: run_req and step_req same cycle with step_count=2 -> state=10, 2 commits; halt_req+run_req in HALTED -> stays 11.
REQ-038 SHALL verify: rst asserted mid-STEP between edges -> cpu_en=0 immediately, state=00, retired=0 before next edge.
